// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared types for the memory arbiter slice: the RAM word, the RAM handshake
//   state, the effective bus owner and the grant-lock register encoding.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } owner_t;

  // Grant lock: either nothing is held, or the RAM is held for one requester.
  typedef enum logic [1:0] {
    LK_IDLE  = 2'd0,
    LK_DATA  = 2'd1,
    LK_INSTR = 2'd2
  } lock_t;

endpackage

// File: rtl/mem_grant_lock.sv
// mem_grant_lock
//   Holds the grant lock and resolves the effective RAM owner.
//   Ports:
//     CLK       system clock, rising edge
//     nRST      synchronous reset, active high
//     dreq      data port requesting (read or write)
//     iREN      instruction port requesting
//     ramstate  RAM handshake state
//     owner     effective owner this cycle (combinational)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   LK_IDLE  | no access in flight; data beats instruction, else none
//   LK_DATA  | RAM went BUSY on a data access; hold data until it ends
//   LK_INSTR | RAM went BUSY on a fetch; hold fetch even if data arrives
module mem_grant_lock
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      dreq,
  input  logic      iREN,
  input  ramstate_t ramstate,
  output owner_t    owner
);

  lock_t lock_q;
  lock_t lock_d;

  always_ff @(posedge CLK) begin
    if (nRST) lock_q <= LK_IDLE;
    else      lock_q <= lock_d;
  end

  always_comb begin
    owner  = NONE;
    lock_d = lock_q;

    case (lock_q)
      LK_DATA:  owner = DATA;
      LK_INSTR: owner = INSTR;
      default: begin
        if (dreq)      owner = DATA;
        else if (iREN) owner = INSTR;
      end
    endcase

    // Release conditions take precedence so an ended or abandoned access
    // never re-locks on the same edge.
    if (ramstate == ACCESS || ramstate == ERROR) begin
      lock_d = LK_IDLE;
    end else if ((lock_q == LK_DATA && !dreq) || (lock_q == LK_INSTR && !iREN)) begin
      lock_d = LK_IDLE;
    end else if (ramstate == BUSY && owner == DATA) begin
      lock_d = LK_DATA;
    end else if (ramstate == BUSY && owner == INSTR) begin
      lock_d = LK_INSTR;
    end
  end

endmodule

// File: rtl/memory_arbiter_ctrl.sv
// memory_arbiter_ctrl
//   Arbitrates one single-port RAM between the instruction-fetch and data
//   ports. Data has priority; a grant lock keeps the RAM address stable once
//   the RAM reports BUSY. Requests reach the RAM in the same cycle.
//   Ports:
//     CLK, nRST                 clock and synchronous active-high reset
//     iREN, iaddr               instruction read request/address
//     dREN, dWEN, daddr, dstore data read/write request, address, write data
//     iwait, dwait              stall per port until its ACCESS cycle
//     iload, dload              read data (straight from ramload)
//     ramstate, ramload         RAM handshake state and read data
//     ramaddr, ramREN, ramWEN, ramstore   RAM command
//   Optional build macro MEMCTRL_STATS_EN adds dcount/icount completed-access
//   counters (32-bit, wrapping, cleared by reset).
module memory_arbiter_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  input  ramstate_t         ramstate,
  input  logic [WORD_W-1:0] ramload,
  output logic [WORD_W-1:0] ramaddr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramstore
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [31:0]       dcount,
  output logic [31:0]       icount
`endif
);

  logic   dreq;
  owner_t owner;

  assign dreq = dREN | dWEN;

  mem_grant_lock u_lock (
    .CLK      (CLK),
    .nRST     (nRST),
    .dreq     (dreq),
    .iREN     (iREN),
    .ramstate (ramstate),
    .owner    (owner)
  );

  always_comb begin
    ramaddr = '0;
    ramREN  = 1'b0;
    ramWEN  = 1'b0;
    case (owner)
      DATA: begin
        ramaddr = daddr;
        ramWEN  = dWEN;
        ramREN  = dREN & ~dWEN;   // write wins when both are raised
      end
      INSTR: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ramstore = dstore;
  assign iload    = ramload;
  assign dload    = ramload;

  assign dwait = dreq & ~((owner == DATA)  && (ramstate == ACCESS));
  assign iwait = iREN & ~((owner == INSTR) && (ramstate == ACCESS));

`ifdef MEMCTRL_STATS_EN
  always_ff @(posedge CLK) begin
    if (nRST) begin
      dcount <= '0;
      icount <= '0;
    end else if (ramstate == ACCESS) begin
      if (owner == DATA)  dcount <= dcount + 32'd1;
      if (owner == INSTR) icount <= icount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter_ctrl.sv
module tb_memory_arbiter_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  ramstate_t   ramstate;
  logic [31:0] ramload;
  logic [31:0] ramaddr;
  logic        ramREN, ramWEN;
  logic [31:0] ramstore;
`ifdef MEMCTRL_STATS_EN
  logic [31:0] dcount, icount;
`endif

  always #5 CLK = ~CLK;

  memory_arbiter_ctrl #(.WORD_W(32)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .iaddr    (iaddr),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramstate (ramstate),
    .ramload  (ramload),
    .ramaddr  (ramaddr),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramstore (ramstore)
`ifdef MEMCTRL_STATS_EN
    ,
    .dcount   (dcount),
    .icount   (icount)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which port (if any) currently holds the RAM.
  bit          m_locked = 1'b0;
  bit          m_lock_instr = 1'b0;
  logic [31:0] m_dcnt = '0;
  logic [31:0] m_icnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge,
  // then advance the model for the coming edge.
  task automatic step(input bit rst, input bit dr, input bit dw, input bit ir,
                      input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] ds, input logic [31:0] rl,
                      input ramstate_t rs);
    bit          dq;
    int          own;     // 0 none, 1 data, 2 instr
    logic [31:0] e_addr;
    bit          e_ren, e_wen, e_dwait, e_iwait;

    @(posedge CLK);
    #1;
    nRST = rst; dREN = dr; dWEN = dw; iREN = ir;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    @(negedge CLK);

    dq = dr | dw;
    if (m_locked)  own = m_lock_instr ? 2 : 1;
    else if (dq)   own = 1;
    else if (ir)   own = 2;
    else           own = 0;

    e_addr  = (own == 1) ? da : (own == 2) ? ia : 32'd0;
    e_ren   = (own == 1) ? (dr && !dw) : (own == 2);
    e_wen   = (own == 1) ? dw : 1'b0;
    e_dwait = dq && !(own == 1 && rs == ACCESS);
    e_iwait = ir && !(own == 2 && rs == ACCESS);

    check("ramaddr",  ramaddr,  e_addr);
    check("ramREN",   {31'd0, ramREN}, {31'd0, e_ren});
    check("ramWEN",   {31'd0, ramWEN}, {31'd0, e_wen});
    check("ramstore", ramstore, ds);
    check("iload",    iload,    rl);
    check("dload",    dload,    rl);
    check("dwait",    {31'd0, dwait}, {31'd0, e_dwait});
    check("iwait",    {31'd0, iwait}, {31'd0, e_iwait});

    if (rst) begin
      m_locked = 1'b0;
      m_dcnt = '0;
      m_icnt = '0;
    end else begin
      if (rs == ACCESS && own == 1) m_dcnt = m_dcnt + 1;
      if (rs == ACCESS && own == 2) m_icnt = m_icnt + 1;
      if (rs == ACCESS || rs == ERROR) m_locked = 1'b0;
      else if (m_locked && (m_lock_instr ? !ir : !dq)) m_locked = 1'b0;
      else if (!m_locked && own != 0 && rs == BUSY) begin
        m_locked = 1'b1;
        m_lock_instr = (own == 2);
      end
    end
  endtask

  initial begin
    nRST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset with a fetch pending: RAM is driven, fetch stalls.
    step(1, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    check("rst_ramREN", {31'd0, ramREN}, 32'd1);
    check("rst_iwait",  {31'd0, iwait},  32'd1);
    step(1, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, BUSY);

    // Instruction only.
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, BUSY);
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h8C010004, ACCESS);
    check("ifetch_iload", iload, 32'h8C010004);
    check("ifetch_iwait", {31'd0, iwait}, 32'd0);

    // Conflict: data wins.
    step(0, 1, 0, 1, 32'h0, 32'h4, 32'h0, 32'h0, FREE);
    check("conf_ramaddr", ramaddr, 32'h4);
    step(0, 1, 0, 1, 32'h0, 32'h4, 32'h0, 32'h0, BUSY);
    step(0, 1, 0, 1, 32'h0, 32'h4, 32'h0, 32'h1234, ACCESS);
    check("conf_dwait", {31'd0, dwait}, 32'd0);
    check("conf_iwait", {31'd0, iwait}, 32'd1);
    step(0, 0, 0, 1, 32'h0, 32'h4, 32'h0, 32'h0, FREE);
    check("conf_after", ramaddr, 32'h0);

    // Writes, with and without a simultaneous read request.
    step(0, 0, 1, 0, 32'h0, 32'h8, 32'hDEADBEEF, 32'h0, FREE);
    check("wr_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("wr_ramstore", ramstore, 32'hDEADBEEF);
    step(0, 1, 1, 0, 32'h0, 32'h8, 32'hDEADBEEF, 32'h0, FREE);
    check("rw_ramREN", {31'd0, ramREN}, 32'd0);

    // Lock held by a fetch while data arrives.
    step(0, 0, 0, 1, 32'h40, 32'h80, 32'h0, 32'h0, BUSY);
    step(0, 1, 0, 1, 32'h40, 32'h80, 32'h0, 32'h0, BUSY);
    check("lock_hold", ramaddr, 32'h40);
    step(0, 1, 0, 1, 32'h40, 32'h80, 32'h0, 32'h0, ACCESS);
    check("lock_access", ramaddr, 32'h40);
    step(0, 1, 0, 1, 32'h40, 32'h80, 32'h0, 32'h0, FREE);
    check("lock_switch", ramaddr, 32'h80);

    // ERROR on a locked data access releases the lock.
    step(0, 1, 0, 0, 32'h40, 32'h80, 32'h0, 32'h0, BUSY);
    step(0, 1, 0, 1, 32'h40, 32'h80, 32'h0, 32'h0, ERROR);
    check("err_dwait", {31'd0, dwait}, 32'd1);
    step(0, 0, 0, 1, 32'h40, 32'h80, 32'h0, 32'h0, FREE);
    check("err_unlock", ramaddr, 32'h40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
           $urandom, $urandom, $urandom, $urandom,
           ramstate_t'($urandom_range(0, 3)));
    end

`ifdef MEMCTRL_STATS_EN
    @(posedge CLK);
    #1;
    check("dcount", dcount, m_dcnt);
    check("icount", icount, m_icnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter_ctrl.md
Name: memory_arbiter_ctrl

Overview:
Single-port memory controller arbitrating one unified RAM between the instruction-fetch and data ports of the pipeline caches. Sits between the cache-control bundle (iREN/dREN/dWEN/iaddr/daddr/dstore) and the RAM bundle (ramaddr/ramREN/ramWEN/ramstore/ramload/ramstate). Data requests have priority over instruction fetch. A grant lock keeps the RAM address stable while an access is in flight.

Parameters:
WORD_W, 32, data/address width (word_t)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  reset; named as codebase does but synchronous, active-high (1 = reset)
iREN  in  1  instruction read request
dREN  in  1  data read request
dWEN  in  1  data write request
iaddr  in  WORD_W  instruction address
daddr  in  WORD_W  data address
dstore  in  WORD_W  data write value
iwait  out  1  instruction port must stall
dwait  out  1  data port must stall
iload  out  WORD_W  instruction read data
dload  out  WORD_W  data read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
ramload  in  WORD_W  RAM read data
ramaddr  out  WORD_W  RAM address
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramstore  out  WORD_W  RAM write data

Behaviour:
- dreq = dREN|dWEN. If dREN and dWEN both high, write wins (ramWEN=1, ramREN=0).
- Owner: registered lock {lock_valid, lock_owner∈{DATA,INSTR}}. Effective owner = lock_owner if lock_valid, else DATA if dreq, else INSTR if iREN, else NONE.
- Outputs (combinational from owner): DATA -> ramaddr=daddr, ramWEN=dWEN, ramREN=dREN&~dWEN. INSTR -> ramaddr=iaddr, ramREN=1, ramWEN=0. NONE -> ramREN=ramWEN=0, ramaddr=0.
- ramstore=dstore always; iload=dload=ramload always.
- dwait = dreq & ~(owner==DATA & ramstate==ACCESS). iwait = iREN & ~(owner==INSTR & ramstate==ACCESS). A requester not granted always sees wait=1.
- Lock: on rising CLK, if owner!=NONE and ramstate==BUSY, lock_valid<=1, lock_owner<=owner. Cleared when ramstate is ACCESS or ERROR, or when the locked requester drops its request. A data request arriving while INSTR is locked waits until the lock clears, then wins.
- ERROR: wait stays asserted for that cycle; lock cleared; request retried next cycle.
- Reset (nRST=1 at edge): lock_valid=0, lock_owner=DATA; outputs follow the combinational rules above with no lock. Reset mid-access drops the lock immediately.
- Zero added latency: a FREE RAM seeing a request is driven the same cycle.

Optional Feature:
MEMCTRL_STATS_EN: adds outputs dcount, icount (32-bit each). These count completed accesses (owner DATA/INSTR with ramstate==ACCESS) per port, cleared on reset and wrapping at 2^32. Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg: word_t (32-bit) and ramstate_t enum {FREE, BUSY, ACCESS, ERROR}; the owner enum {NONE, DATA, INSTR} also belongs there.
- Optional submodule mem_grant_lock holding the lock register and owner selection; the top does output muxing.

Test Plan:
- Reset: nRST=1, iREN=1, iaddr=0 -> lock_valid=0, ramREN=1, ramaddr=0, iwait=1 until ramstate=ACCESS.
- Instr only: iREN=1, iaddr=0x0, RAM returns 0x8C010004 on ACCESS -> iload=0x8C010004, iwait=0 that cycle.
- Conflict: dREN=1, daddr=4, iREN=1, iaddr=0, RAM FREE -> ramaddr=4, ramREN=1, dwait=1 until ACCESS, iwait=1 throughout; after data completes and dREN drops -> ramaddr=0.
- Write: dWEN=1, daddr=8, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dREN=dWEN=1 gives the same result.
- Lock: INSTR access at BUSY, then dREN=1 -> ramaddr stays iaddr until ACCESS, then switches to daddr next cycle.
- ERROR on data access -> dwait=1, lock cleared; with MEMCTRL_STATS_EN, dcount is unchanged and increments only on ACCESS.
